// File: rtl/fix_point_mult.sv
// fix_point_mult: signed fixed-point multiplier with saturation.
// Multiplies two Q(WIDTH-FRAC).FRAC operands, rescales the exact product back
// to the input format (truncating toward -inf), and clamps results that do
// not fit. The result and overflow flag are registered with one cycle of
// latency, and valid_o pulses once for every accepted valid_i.
module fix_point_mult #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] c_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] product;
    logic signed [2*WIDTH-1:0] shifted;
    logic        [WIDTH:0]     upper_bits;
    logic                      fits;
    logic        [WIDTH-1:0]   sat_result;
    logic                      sat_ovf;

    logic [WIDTH-1:0] c_d, c_q;
    logic             ovf_d, ovf_q;
    logic             valid_d, valid_q;

    // Exact product, rescale by 2^-FRAC, then saturate if it leaves the word range.
    always_comb begin
        a_ext      = {{WIDTH{a_i[WIDTH-1]}}, a_i};
        b_ext      = {{WIDTH{b_i[WIDTH-1]}}, b_i};
        product    = a_ext * b_ext;
        shifted    = product >>> FRAC;
        upper_bits = shifted[2*WIDTH-1:WIDTH-1];
        fits       = (&upper_bits) || (~|upper_bits);
        sat_result = shifted[WIDTH-1:0];
        sat_ovf    = 1'b0;
        if (!fits) begin
            sat_ovf    = 1'b1;
            sat_result = shifted[2*WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    // Next-state: capture a new result on valid_i, otherwise hold the last one.
    always_comb begin
        valid_d = valid_i;
        c_d     = c_q;
        ovf_d   = ovf_q;
        if (valid_i) begin
            c_d   = sat_result;
            ovf_d = sat_ovf;
        end
    end

    // Output registers; reset clears them at once and drops any in-flight result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            c_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign c_o     = c_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_fix_point_mult.sv
// tb_fix_point_mult: table-driven and randomized checks of fix_point_mult.
module tb_fix_point_mult;

    logic        clk_i;
    logic        rst_n_i;
    logic        valid_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] c_o;
    logic        valid_o;
    logic        ovf_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] model_c;
    logic        model_ovf;

    fix_point_mult #(.WIDTH(32), .FRAC(16)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_o     (c_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: exact product with 64-bit integers, floor-divide by 2^16, clamp.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] c, output logic ovf);
        longint p;
        longint r;
        p = longint'($signed(a)) * longint'($signed(b));
        r = p >>> 16;
        if (r > 64'sd2147483647) begin
            c = 32'h7FFFFFFF;
            ovf = 1'b1;
        end else if (r < -64'sd2147483648) begin
            c = 32'h80000000;
            ovf = 1'b1;
        end else begin
            c = r[31:0];
            ovf = 1'b0;
        end
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i = v;
        a_i     = a;
        b_i     = b;
    endtask

    task automatic sample_after_edge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        rst_n_i = 1'b0;

        vecs.push_back('{32'h00000CCC, 32'hFFFFCCCD, 32'hFFFFFD70, 1'b0});
        vecs.push_back('{32'h00003333, 32'hFFFFCCCD, 32'hFFFFF5C2, 1'b0});
        vecs.push_back('{32'h00050000, 32'hFFFF8000, 32'hFFFD8000, 1'b0});
        vecs.push_back('{32'h00050000, 32'h00008000, 32'h00028000, 1'b0});
        vecs.push_back('{32'hFFFB0000, 32'hFFFFBE5D, 32'h0001482F, 1'b0});
        vecs.push_back('{32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1});
        vecs.push_back('{32'h80000000, 32'h00020000, 32'h80000000, 1'b1});
        vecs.push_back('{32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b0});
        vecs.push_back('{32'h80000000, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b1});
        vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{32'h00010000, 32'h00010000, 32'h00010000, 1'b0});
        vecs.push_back('{32'h00000001, 32'h00000001, 32'h00000000, 1'b0});

        // Reset state
        #1;
        check_output("reset_c", c_o, 32'h0);
        check_output("reset_valid", {31'b0, valid_o}, 32'h0);
        check_output("reset_ovf", {31'b0, ovf_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Table vectors, driven back-to-back: one result per cycle
        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].a, vecs[i].b);
            sample_after_edge();
            check_output($sformatf("vec%0d_c", i), c_o, vecs[i].exp_c);
            check_output($sformatf("vec%0d_ovf", i), {31'b0, ovf_o}, {31'b0, vecs[i].exp_ovf});
            check_output($sformatf("vec%0d_valid", i), {31'b0, valid_o}, 32'h1);
        end

        // Hold: load a known result, then idle for 3 cycles
        apply_stimulus(1'b1, 32'h00050000, 32'hFFFF8000);
        sample_after_edge();
        check_output("hold_load_c", c_o, 32'hFFFD8000);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 32'h12345678, 32'h7FFFFFFF);
            sample_after_edge();
            check_output($sformatf("hold%0d_c", k), c_o, 32'hFFFD8000);
            check_output($sformatf("hold%0d_valid", k), {31'b0, valid_o}, 32'h0);
            check_output($sformatf("hold%0d_ovf", k), {31'b0, ovf_o}, 32'h0);
        end

        // Saturated result, then asynchronous reset between edges mid-operation
        apply_stimulus(1'b1, 32'h7FFF0000, 32'h00020000);
        sample_after_edge();
        check_output("pre_rst_ovf", {31'b0, ovf_o}, 32'h1);
        apply_stimulus(1'b1, 32'h00050000, 32'h00008000);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_output("async_rst_c", c_o, 32'h0);
        check_output("async_rst_valid", {31'b0, valid_o}, 32'h0);
        check_output("async_rst_ovf", {31'b0, ovf_o}, 32'h0);
        sample_after_edge();
        check_output("rst_held_valid", {31'b0, valid_o}, 32'h0);
        check_output("rst_held_c", c_o, 32'h0);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_n_i = 1'b1;
        sample_after_edge();
        check_output("post_rst_valid", {31'b0, valid_o}, 32'h0);
        check_output("post_rst_c", c_o, 32'h0);

        // Randomized traffic against the reference model
        model_c   = 32'h0;
        model_ovf = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic        v;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 2);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) begin
                ra = 32'($signed(ra) >>> $urandom_range(8, 20));
                rb = 32'($signed(rb) >>> $urandom_range(8, 20));
            end else if (sel == 1) begin
                ra = 32'($signed(ra) >>> $urandom_range(0, 16));
            end
            apply_stimulus(v, ra, rb);
            if (v) ref_model(ra, rb, model_c, model_ovf);
            sample_after_edge();
            check_output($sformatf("rnd%0d_c", n), c_o, model_c);
            check_output($sformatf("rnd%0d_ovf", n), {31'b0, ovf_o}, {31'b0, model_ovf});
            check_output($sformatf("rnd%0d_valid", n), {31'b0, valid_o}, {31'b0, v});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
